// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, loader FSM state type and the frame-buffer
// address packing helper used by the 64x64 matrix frame loader.
package matrix_pkg;

    localparam int MATRIX_W = 64;
    localparam int MATRIX_H = 64;
    localparam int PIX_BITS = 12;
    localparam int COORD_W  = 6;
    localparam int ADDR_W   = 1 + 2 * COORD_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SWAP      = 2'd2,
        WAIT_SWAP = 2'd3
    } loader_state_t;

    // Driver write address: buffer bit on top, then row, then column.
    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic               buf_sel,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] x
    );
        return {buf_sel, y, x};
    endfunction

endpackage

// File: rtl/matrix_gamma_8to4.sv
// matrix_gamma_8to4: maps one 8-bit colour channel to 4 bits with a registered
// output. GAMMA_EN=1 uses a gamma-2.2 table, GAMMA_EN=0 keeps the top nibble.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   x    - 8-bit channel value
//   y    - 4-bit mapped value, one clock after x
module matrix_gamma_8to4 #(
    parameter int GAMMA_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x,
    output logic [3:0] y
);

    // round(15*(v/255)^2.2) expressed as the first input value reaching each
    // output code; this is a 256x4 ROM written as a threshold ladder.
    function automatic logic [3:0] gamma22(input logic [7:0] v);
        logic [3:0] g;
        if      (v >= 8'd252) g = 4'd15;
        else if (v >= 8'd244) g = 4'd14;
        else if (v >= 8'd235) g = 4'd13;
        else if (v >= 8'd226) g = 4'd12;
        else if (v >= 8'd217) g = 4'd11;
        else if (v >= 8'd208) g = 4'd10;
        else if (v >= 8'd197) g = 4'd9;
        else if (v >= 8'd187) g = 4'd8;
        else if (v >= 8'd175) g = 4'd7;
        else if (v >= 8'd162) g = 4'd6;
        else if (v >= 8'd148) g = 4'd5;
        else if (v >= 8'd132) g = 4'd4;
        else if (v >= 8'd113) g = 4'd3;
        else if (v >= 8'd90)  g = 4'd2;
        else if (v >= 8'd55)  g = 4'd1;
        else                  g = 4'd0;
        return g;
    endfunction

    logic [3:0] lut_s;
    logic [3:0] y_r;

    // Table lookup or plain truncation, selected at elaboration.
    always_comb begin
        lut_s = 4'd0;
        if (GAMMA_EN != 0) begin
            lut_s = gamma22(x);
        end else begin
            lut_s = x[7:4];
        end
    end

    // Registered ROM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r <= 4'd0;
        end else begin
            y_r <= lut_s;
        end
    end

    assign y = y_r;

endmodule

// File: rtl/matrix_frame_loader.sv
// matrix_frame_loader: accepts raster-order RGB888 pixels, gamma-maps them to
// RGB444 and writes them into the panel driver's back buffer, then flips
// buffer_select and waits for the driver to confirm the swap.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   s_valid/s_ready/s_data   - pixel stream {R,G,B}, s_sof marks pixel (0,0)
//   wr/wr_addr/wr_data       - driver write port {buf,y,x} / {R4,G4,B4}
//   buffer_select            - buffer the driver should display
//   buffer_current           - buffer the driver displays (other clock domain)
//   frame_done               - one-cycle pulse on confirmed swap
//   frame_count/resync_count - completed frames (wraps) / aborted frames (saturates)
module matrix_frame_loader
    import matrix_pkg::*;
#(
    parameter int GAMMA_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [23:0]         s_data,
    input  logic                s_sof,
    output logic                wr,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [PIX_BITS-1:0] wr_data,
    output logic                buffer_select,
    input  logic                buffer_current,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic [7:0]          resync_count
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MATRIX_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MATRIX_H - 1);

    loader_state_t       state_r, state_nx_s;
    logic [COORD_W-1:0]  x_r, y_r, x_nx_s, y_nx_s;
    logic [COORD_W-1:0]  pix_x_s, pix_y_s;
    logic                accept_s, take_s, resync_s, flip_s, done_s;
    logic                sync_meta_r, cur_sync_r;
    logic                v1_r;
    logic [ADDR_W-1:0]   addr1_r;
    logic                s_ready_r, wr_r, buf_sel_r, frame_done_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [PIX_BITS-1:0] wr_data_r;
    logic [15:0]         frame_count_r;
    logic [7:0]          resync_count_r;
    logic [3:0]          r4_s, g4_s, b4_s;

    assign accept_s = s_valid && s_ready_r;

    matrix_gamma_8to4 #(.GAMMA_EN(GAMMA_EN)) u_gamma_r (
        .clk(clk), .rst(rst), .x(s_data[23:16]), .y(r4_s)
    );
    matrix_gamma_8to4 #(.GAMMA_EN(GAMMA_EN)) u_gamma_g (
        .clk(clk), .rst(rst), .x(s_data[15:8]), .y(g4_s)
    );
    matrix_gamma_8to4 #(.GAMMA_EN(GAMMA_EN)) u_gamma_b (
        .clk(clk), .rst(rst), .x(s_data[7:0]), .y(b4_s)
    );

    // Next-state, raster position and event decode.
    always_comb begin
        state_nx_s = state_r;
        x_nx_s     = x_r;
        y_nx_s     = y_r;
        pix_x_s    = x_r;
        pix_y_s    = y_r;
        take_s     = 1'b0;
        resync_s   = 1'b0;
        flip_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && s_sof) begin
                    take_s     = 1'b1;
                    pix_x_s    = '0;
                    pix_y_s    = '0;
                    x_nx_s     = COORD_W'(1);
                    y_nx_s     = '0;
                    state_nx_s = LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    take_s = 1'b1;
                    if (s_sof) begin
                        // Early start of frame: restart at (0,0) in the same
                        // back buffer; the partial frame is overwritten.
                        pix_x_s  = '0;
                        pix_y_s  = '0;
                        x_nx_s   = COORD_W'(1);
                        y_nx_s   = '0;
                        resync_s = 1'b1;
                    end else begin
                        x_nx_s = x_r + COORD_W'(1);
                        if (x_r == X_LAST) begin
                            y_nx_s = y_r + COORD_W'(1);
                            if (y_r == Y_LAST) begin
                                state_nx_s = SWAP;
                            end else begin
                                state_nx_s = LOAD;
                            end
                        end else begin
                            state_nx_s = LOAD;
                        end
                    end
                end else begin
                    state_nx_s = LOAD;
                end
            end
            SWAP: begin
                // Once stage 1 is empty the final write is on the port this
                // cycle, so flipping now cannot redirect it.
                if (!v1_r) begin
                    flip_s     = 1'b1;
                    state_nx_s = WAIT_SWAP;
                end else begin
                    state_nx_s = SWAP;
                end
            end
            WAIT_SWAP: begin
                if (cur_sync_r == buf_sel_r) begin
                    done_s     = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_SWAP;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state and raster position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
        end else begin
            state_r <= state_nx_s;
            x_r     <= x_nx_s;
            y_r     <= y_nx_s;
        end
    end

    // Two-flop synchronizer for the driver's displayed-buffer flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b0;
            cur_sync_r  <= 1'b0;
        end else begin
            sync_meta_r <= buffer_current;
            cur_sync_r  <= sync_meta_r;
        end
    end

    // Control outputs: ready, buffer flip, swap pulse and frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready_r      <= 1'b0;
            buf_sel_r      <= 1'b0;
            frame_done_r   <= 1'b0;
            frame_count_r  <= 16'd0;
            resync_count_r <= 8'd0;
        end else begin
            s_ready_r    <= (state_nx_s == IDLE) || (state_nx_s == LOAD);
            frame_done_r <= done_s;
            if (flip_s) begin
                buf_sel_r <= ~buf_sel_r;
            end
            if (done_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (resync_s && (resync_count_r != 8'hFF)) begin
                resync_count_r <= resync_count_r + 8'd1;
            end
        end
    end

    // Stage 1: latch the write address at accept time, alongside the LUTs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r    <= 1'b0;
            addr1_r <= '0;
        end else begin
            v1_r <= take_s;
            if (take_s) begin
                addr1_r <= pack_addr(~buf_sel_r, pix_y_s, pix_x_s);
            end
        end
    end

    // Stage 2: driver write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_r      <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            wr_r <= v1_r;
            if (v1_r) begin
                wr_addr_r <= addr1_r;
                wr_data_r <= {r4_s, g4_s, b4_s};
            end
        end
    end

    assign s_ready       = s_ready_r;
    assign wr            = wr_r;
    assign wr_addr       = wr_addr_r;
    assign wr_data       = wr_data_r;
    assign buffer_select = buf_sel_r;
    assign frame_done    = frame_done_r;
    assign frame_count   = frame_count_r;
    assign resync_count  = resync_count_r;

endmodule
